vga_timing_gen: RTL and testbench

// Parametrised VGA raster engine; successor to the fixed 640x480 VGA block driven from the DE2_115 top.

---
 rtl/vga_timing_gen.sv | 189 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Programmable VGA raster engine: pixel-tick divider, h/v counters, fetch requests to a
// frame source and a FETCH_LAT-deep realignment of sync/blank with the returned colour.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 2,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int COLOR_W   = 8,
    parameter int FETCH_LAT = 2
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   en,
    output logic                                                   req_valid,
    output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]           req_x,
    output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]           req_y,
    input  logic [COLOR_W-1:0]                                     pix_r,
    input  logic [COLOR_W-1:0]                                     pix_g,
    input  logic [COLOR_W-1:0]                                     pix_b,
    output logic                                                   VGA_CLK,
    output logic                                                   VGA_HS,
    output logic                                                   VGA_VS,
    output logic                                                   VGA_BLANK_N,
    output logic                                                   VGA_SYNC_N,
    output logic [COLOR_W-1:0]                                     VGA_R,
    output logic [COLOR_W-1:0]                                     VGA_G,
    output logic [COLOR_W-1:0]                                     VGA_B,
    output logic                                                   frame_start,
    output logic                                                   busy
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic          HS_ON    = (HS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic          VS_ON    = (VS_POL != 0) ? 1'b1 : 1'b0;
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [3:0]    DRAIN_LAST = 4'(FETCH_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_r;
    logic [DW-1:0]          div_cnt_r;
    logic [HW-1:0]          h_cnt_r;
    logic [VW-1:0]          v_cnt_r;
    logic [3:0]             drain_cnt_r;
    logic [FETCH_LAT-1:0]   hs_pipe_r;
    logic [FETCH_LAT-1:0]   vs_pipe_r;
    logic [FETCH_LAT-1:0]   act_pipe_r;

    logic                   tick_s;
    logic [DW-1:0]          div_nxt_s;
    logic                   h_last_s;
    logic                   v_last_s;
    logic                   act_s;
    logic                   hs_in_s;
    logic                   vs_in_s;
    logic                   act_in_s;
    logic                   start_s;

    assign VGA_SYNC_N = 1'b0;

    // Tick decode and raw sync/blank from the counters; drain pushes idle levels.
    always_comb begin
        tick_s    = (state_r != ST_IDLE) && (div_cnt_r == DIV_LAST);
        div_nxt_s = tick_s ? {DW{1'b0}} : div_cnt_r + DW'(1);
        h_last_s  = (h_cnt_r == H_LAST);
        v_last_s  = (v_cnt_r == V_LAST);
        act_s     = (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
        hs_in_s   = ~HS_ON;
        vs_in_s   = ~VS_ON;
        act_in_s  = 1'b0;
        if (state_r == ST_RUN) begin
            hs_in_s  = ((h_cnt_r >= HS_BEG) && (h_cnt_r < HS_END)) ? HS_ON : ~HS_ON;
            vs_in_s  = ((v_cnt_r >= VS_BEG) && (v_cnt_r < VS_END)) ? VS_ON : ~VS_ON;
            act_in_s = act_s;
        end else begin
            hs_in_s  = ~HS_ON;
            vs_in_s  = ~VS_ON;
            act_in_s = 1'b0;
        end
        start_s   = en && !rst;
    end

    // Sequencer, raster counters, realignment pipeline and registered VGA outputs.
    always_ff @(posedge clk) begin
        if (rst || (state_r == ST_IDLE)) begin
            state_r     <= start_s ? ST_RUN : ST_IDLE;
            busy        <= start_s;
            VGA_CLK     <= start_s;
            div_cnt_r   <= {DW{1'b0}};
            h_cnt_r     <= {HW{1'b0}};
            v_cnt_r     <= {VW{1'b0}};
            drain_cnt_r <= 4'd0;
            hs_pipe_r   <= {FETCH_LAT{~HS_ON}};
            vs_pipe_r   <= {FETCH_LAT{~VS_ON}};
            act_pipe_r  <= {FETCH_LAT{1'b0}};
            req_valid   <= 1'b0;
            req_x       <= {HW{1'b0}};
            req_y       <= {VW{1'b0}};
            frame_start <= 1'b0;
            VGA_HS      <= ~HS_ON;
            VGA_VS      <= ~VS_ON;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= {COLOR_W{1'b0}};
            VGA_G       <= {COLOR_W{1'b0}};
            VGA_B       <= {COLOR_W{1'b0}};
        end else begin
            div_cnt_r   <= div_nxt_s;
            VGA_CLK     <= (div_nxt_s < DIV_HALF);
            req_valid   <= 1'b0;
            frame_start <= 1'b0;
            if (tick_s) begin
                hs_pipe_r[0]  <= hs_in_s;
                vs_pipe_r[0]  <= vs_in_s;
                act_pipe_r[0] <= act_in_s;
                for (int i = 1; i < FETCH_LAT; i++) begin
                    hs_pipe_r[i]  <= hs_pipe_r[i-1];
                    vs_pipe_r[i]  <= vs_pipe_r[i-1];
                    act_pipe_r[i] <= act_pipe_r[i-1];
                end
                VGA_HS      <= hs_pipe_r[FETCH_LAT-1];
                VGA_VS      <= vs_pipe_r[FETCH_LAT-1];
                VGA_BLANK_N <= act_pipe_r[FETCH_LAT-1];
                VGA_R       <= act_pipe_r[FETCH_LAT-1] ? pix_r : {COLOR_W{1'b0}};
                VGA_G       <= act_pipe_r[FETCH_LAT-1] ? pix_g : {COLOR_W{1'b0}};
                VGA_B       <= act_pipe_r[FETCH_LAT-1] ? pix_b : {COLOR_W{1'b0}};
            end
            case (state_r)
                ST_RUN: begin
                    if (tick_s) begin
                        req_valid   <= act_s;
                        req_x       <= h_cnt_r;
                        req_y       <= v_cnt_r;
                        frame_start <= (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
                        if (h_last_s) begin
                            h_cnt_r <= {HW{1'b0}};
                            v_cnt_r <= v_last_s ? {VW{1'b0}} : v_cnt_r + VW'(1);
                        end else begin
                            h_cnt_r <= h_cnt_r + HW'(1);
                        end
                        // en is only honoured on the last pixel of a frame
                        if (h_last_s && v_last_s && !en) begin
                            state_r     <= ST_DRAIN;
                            busy        <= 1'b0;
                            drain_cnt_r <= 4'd0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (tick_s) begin
                        drain_cnt_r <= drain_cnt_r + 4'd1;
                        if (drain_cnt_r == DRAIN_LAST) begin
                            state_r   <= ST_IDLE;
                            div_cnt_r <= {DW{1'b0}};
                            VGA_CLK   <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-size instances compared every clock against a
// raster model computed from tick index arithmetic.
module tb_vga_timing_gen;
    typedef struct {
        int ha, hf, hsw, hb, va, vf, vsw, vb, d, hp, vp, l;
    } prm_t;

    typedef struct packed {
        logic        rv;
        logic [15:0] rx;
        logic [15:0] ry;
        logic        fs;
        logic        busy;
        logic        vclk;
        logic        hs;
        logic        vs;
        logic        bn;
        logic        sn;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } obs_t;

    localparam prm_t PA = '{32, 4, 6, 6, 20, 2, 2, 3, 2, 0, 0, 2};
    localparam prm_t PB = '{8, 2, 2, 2, 4, 1, 1, 1, 4, 1, 0, 2};
    localparam longint NEVER = 64'd1 << 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0;
    logic en_b = 1'b0;
    logic [7:0] pix_r = 8'd0, pix_g = 8'd0, pix_b = 8'd0;

    logic       a_rv, a_vclk, a_hs, a_vs, a_bn, a_sn, a_fs, a_busy;
    logic [5:0] a_rx;
    logic [4:0] a_ry;
    logic [7:0] a_r, a_g, a_b;
    logic       b_rv, b_vclk, b_hs, b_vs, b_bn, b_sn, b_fs, b_busy;
    logic [3:0] b_rx;
    logic [2:0] b_ry;
    logic [7:0] b_r, b_g, b_b;

    int total = 0;
    int bad = 0;
    int salt = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(32), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(2), .HS_POL(0), .VS_POL(0), .COLOR_W(8), .FETCH_LAT(2)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en_a),
        .req_valid(a_rv), .req_x(a_rx), .req_y(a_ry),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .VGA_CLK(a_vclk), .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_BLANK_N(a_bn),
        .VGA_SYNC_N(a_sn), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
        .frame_start(a_fs), .busy(a_busy)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(4), .HS_POL(1), .VS_POL(0), .COLOR_W(8), .FETCH_LAT(2)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en_b),
        .req_valid(b_rv), .req_x(b_rx), .req_y(b_ry),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .VGA_CLK(b_vclk), .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_BLANK_N(b_bn),
        .VGA_SYNC_N(b_sn), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
        .frame_start(b_fs), .busy(b_busy)
    );

    function automatic longint htot(prm_t p);
        return longint'(p.ha + p.hf + p.hsw + p.hb);
    endfunction

    function automatic longint vtot(prm_t p);
        return longint'(p.va + p.vf + p.vsw + p.vb);
    endfunction

    function automatic logic [23:0] col(int x, int y);
        logic [23:0] cv;
        cv[23:16] = 8'(x);
        cv[15:8]  = 8'(y);
        cv[7:0]   = 8'(x * 7 + y * 13 + salt);
        return cv;
    endfunction

    function automatic obs_t idle_val(prm_t p);
        obs_t o;
        o    = '0;
        o.hs = (p.hp == 0);
        o.vs = (p.vp == 0);
        return o;
    endfunction

    // Expected outputs c clocks after the edge that accepted en; F = ticks before stopping.
    function automatic obs_t model(prm_t p, longint c, longint F);
        obs_t o;
        longint mt, q;
        int x, y;
        logic [23:0] cv;
        o = idle_val(p);
        if (c > p.d * (F + p.l)) return o;
        o.vclk = (c < p.d * (F + p.l)) && ((c % p.d) < (p.d / 2));
        o.busy = (c < p.d * F);
        mt = c / p.d - 1;
        if (mt >= 0 && mt < F && (c % p.d) == 0) begin
            x = int'(mt % htot(p));
            y = int'((mt / htot(p)) % vtot(p));
            o.rv = (x < p.ha) && (y < p.va);
            o.fs = (x == 0) && (y == 0);
            if (o.rv) begin
                o.rx = 16'(x);
                o.ry = 16'(y);
            end
        end
        q = mt - p.l;
        if (q >= 0 && q < F) begin
            x = int'(q % htot(p));
            y = int'((q / htot(p)) % vtot(p));
            o.hs = (x >= p.ha + p.hf && x < p.ha + p.hf + p.hsw) ? (p.hp != 0) : (p.hp == 0);
            o.vs = (y >= p.va + p.vf && y < p.va + p.vf + p.vsw) ? (p.vp != 0) : (p.vp == 0);
            o.bn = (x < p.ha) && (y < p.va);
            if (o.bn) begin
                cv  = col(x, y);
                o.r = cv[23:16];
                o.g = cv[15:8];
                o.b = cv[7:0];
            end
        end
        return o;
    endfunction

    function automatic obs_t sample(bit s, logic keep_xy);
        obs_t o;
        if (s) begin
            o = '{b_rv, 16'(b_rx), 16'(b_ry), b_fs, b_busy, b_vclk, b_hs, b_vs, b_bn, b_sn, b_r, b_g, b_b};
        end else begin
            o = '{a_rv, 16'(a_rx), 16'(a_ry), a_fs, a_busy, a_vclk, a_hs, a_vs, a_bn, a_sn, a_r, a_g, a_b};
        end
        if (!keep_xy) begin
            o.rx = 16'd0;
            o.ry = 16'd0;
        end
        return o;
    endfunction

    // Frame source: returns the colour of the pixel the next tick will sample, junk when blanked.
    task automatic drive_pix(prm_t p, longint c, longint F);
        longint q;
        int x, y;
        logic [23:0] cv;
        q = c / p.d - p.l;
        x = -1;
        y = -1;
        if (q >= 0 && q < F) begin
            x = int'(q % htot(p));
            y = int'((q / htot(p)) % vtot(p));
        end
        if (x >= 0 && x < p.ha && y >= 0 && y < p.va) begin
            cv = col(x, y);
        end else begin
            cv = 24'($urandom);
        end
        pix_r = cv[23:16];
        pix_g = cv[15:8];
        pix_b = cv[7:0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        en_a = 1'b0;
        en_b = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o, e;
        @(negedge clk);
        rst  = 1'b1;
        en_a = 1'b1;
        en_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                e = idle_val(s == 1 ? PB : PA);
                o = sample(s == 1, 1'b0);
                total++;
                if (o !== e) begin
                    bad++;
                    $display("FAIL reset dut=%0d got=%h exp=%h", s, o, e);
                end
            end
        end
        rst  = 1'b0;
        en_a = 1'b0;
        en_b = 1'b0;
    endtask

    task automatic test_frames();
        obs_t o, e;
        longint fr, last_c;
        int nf, nreq, hs_low, vs_low, fall1, fall2;
        logic prev_hs;
        fr = htot(PA) * vtot(PA);
        last_c = 2 * PA.d * fr + 40;
        nf = 0; nreq = 0; hs_low = 0; vs_low = 0; fall1 = -1; fall2 = -1; prev_hs = 1'b1;
        salt = int'($urandom_range(0, 255));
        do_reset();
        en_a = 1'b1;
        for (longint c = 0; c < last_c; c++) begin
            @(negedge clk);
            e = model(PA, c, NEVER);
            o = sample(1'b0, e.rv);
            total++;
            if (o !== e) begin
                bad++;
                if (nf < 8) $display("FAIL frames c=%0d got=%h exp=%h", c, o, e);
                nf++;
            end
            if (o.rv && c <= PA.d * fr) nreq++;
            if (c >= PA.d * (htot(PA) + PA.l + 1) && c < PA.d * (2 * htot(PA) + PA.l + 1) && !o.hs) hs_low++;
            if (c >= PA.d * (PA.l + 1) && c < PA.d * (fr + PA.l + 1) && !o.vs) vs_low++;
            if (prev_hs && !o.hs) begin
                if (fall1 < 0) fall1 = int'(c);
                else if (fall2 < 0) fall2 = int'(c);
            end
            prev_hs = o.hs;
            drive_pix(PA, c, NEVER);
        end
        total++;
        if (nreq !== PA.ha * PA.va) begin
            bad++;
            $display("FAIL req_count got=%0d exp=%0d", nreq, PA.ha * PA.va);
        end
        total++;
        if (hs_low !== PA.hsw * PA.d) begin
            bad++;
            $display("FAIL hs_width got=%0d exp=%0d", hs_low, PA.hsw * PA.d);
        end
        total++;
        if (vs_low !== PA.vsw * int'(htot(PA)) * PA.d) begin
            bad++;
            $display("FAIL vs_width got=%0d exp=%0d", vs_low, PA.vsw * int'(htot(PA)) * PA.d);
        end
        total++;
        if (fall2 - fall1 !== int'(htot(PA)) * PA.d) begin
            bad++;
            $display("FAIL hs_period got=%0d exp=%0d", fall2 - fall1, int'(htot(PA)) * PA.d);
        end
    endtask

    task automatic test_stop();
        obs_t o, e;
        longint fr, drop_c, F, last_c;
        int nf;
        fr = htot(PA) * vtot(PA);
        drop_c = PA.d * fr + PA.d * htot(PA) * longint'($urandom_range(1, 24))
                 + longint'($urandom_range(0, 95));
        F = fr * ((drop_c + PA.d * fr - 1) / (PA.d * fr));
        last_c = PA.d * (F + PA.l) + 30;
        nf = 0;
        salt = int'($urandom_range(0, 255));
        do_reset();
        en_a = 1'b1;
        for (longint c = 0; c < last_c; c++) begin
            @(negedge clk);
            e = model(PA, c, F);
            o = sample(1'b0, e.rv);
            total++;
            if (o !== e) begin
                bad++;
                if (nf < 8) $display("FAIL stop c=%0d got=%h exp=%h", c, o, e);
                nf++;
            end
            drive_pix(PA, c, F);
            if (c + 1 == drop_c) en_a = 1'b0;
            if (c + 1 >= drop_c && c < last_c - 1 && $urandom_range(0, 1) == 1) en_a = 1'b0;
        end
        // restart from IDLE must line frame_start up with (0,0) again
        en_a = 1'b1;
        for (longint c = 0; c < 2 * PA.d * htot(PA); c++) begin
            @(negedge clk);
            e = model(PA, c, NEVER);
            o = sample(1'b0, e.rv);
            total++;
            if (o !== e) begin
                bad++;
                if (nf < 8) $display("FAIL restart c=%0d got=%h exp=%h", c, o, e);
                nf++;
            end
            drive_pix(PA, c, NEVER);
        end
    endtask

    task automatic test_reset_midline();
        obs_t o, e;
        longint rst_c;
        int nf;
        nf = 0;
        rst_c = PA.d * htot(PA) * longint'($urandom_range(2, 15)) + longint'($urandom_range(3, 90));
        salt = int'($urandom_range(0, 255));
        do_reset();
        en_a = 1'b1;
        for (longint c = 0; c < rst_c; c++) begin
            @(negedge clk);
            e = model(PA, c, NEVER);
            o = sample(1'b0, e.rv);
            total++;
            if (o !== e) begin
                bad++;
                if (nf < 8) $display("FAIL midrun c=%0d got=%h exp=%h", c, o, e);
                nf++;
            end
            drive_pix(PA, c, NEVER);
        end
        rst = 1'b1;
        @(negedge clk);
        e = idle_val(PA);
        o = sample(1'b0, 1'b0);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL rst_midline got=%h exp=%h", o, e);
        end
        rst = 1'b0;
        for (longint c = 0; c < 3 * PA.d * htot(PA); c++) begin
            @(negedge clk);
            e = model(PA, c, NEVER);
            o = sample(1'b0, e.rv);
            total++;
            if (o !== e) begin
                bad++;
                if (nf < 8) $display("FAIL post_rst c=%0d got=%h exp=%h", c, o, e);
                nf++;
            end
            drive_pix(PA, c, NEVER);
        end
    endtask

    task automatic test_small_mode();
        obs_t o, e;
        longint fr;
        int nf, hs_high, rise1, rise2;
        logic prev_hs;
        fr = htot(PB) * vtot(PB);
        nf = 0; hs_high = 0; rise1 = -1; rise2 = -1; prev_hs = 1'b0;
        salt = int'($urandom_range(0, 255));
        do_reset();
        en_b = 1'b1;
        for (longint c = 0; c < 2 * PB.d * fr + 20; c++) begin
            @(negedge clk);
            e = model(PB, c, NEVER);
            o = sample(1'b1, e.rv);
            total++;
            if (o !== e) begin
                bad++;
                if (nf < 8) $display("FAIL small c=%0d got=%h exp=%h", c, o, e);
                nf++;
            end
            if (c >= PB.d * (PB.l + 1) && c < PB.d * (htot(PB) + PB.l + 1) && o.hs) hs_high++;
            if (!prev_hs && o.hs) begin
                if (rise1 < 0) rise1 = int'(c);
                else if (rise2 < 0) rise2 = int'(c);
            end
            prev_hs = o.hs;
            drive_pix(PB, c, NEVER);
        end
        total++;
        if (hs_high !== 8) begin
            bad++;
            $display("FAIL small_hs_width got=%0d exp=8", hs_high);
        end
        total++;
        if (rise2 - rise1 !== 56) begin
            bad++;
            $display("FAIL small_hs_period got=%0d exp=56", rise2 - rise1);
        end
        en_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frames();
        test_stop();
        test_reset_midline();
        test_small_mode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
